// File: rtl/vALU_pkg.sv
// Shared encodings for the vALU multiplier operand path: element widths,
// signedness selects and the sequencer state type.
package vALU_pkg;

  localparam logic [1:0] SEW8  = 2'b00;
  localparam logic [1:0] SEW16 = 2'b01;
  localparam logic [1:0] SEW32 = 2'b10;
  localparam logic [1:0] SEW64 = 2'b11;

  localparam logic [1:0] OPSEL_UU     = 2'b00;
  localparam logic [1:0] OPSEL_SS     = 2'b01;
  localparam logic [1:0] OPSEL_SU     = 2'b10;
  localparam logic [1:0] OPSEL_SS_ALT = 2'b11;

  localparam int OUTPUT_WIDTH_DEF = 18;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HI   = 1'b1
  } state_e;

endpackage

// File: rtl/operand_slice.sv
// Combinational slot mapper for one 64-bit lane: turns A/B into eight
// extended multiplier operand pairs for the selected element width.
module operand_slice
  import vALU_pkg::*;
#(
  parameter int OUTPUT_WIDTH = OUTPUT_WIDTH_DEF,
  parameter int SEW_WIDTH    = 2
) (
  input  logic [63:0]               a,
  input  logic [63:0]               b,
  input  logic [SEW_WIDTH-1:0]      sew,
  input  logic                      a_signed,
  input  logic                      b_signed,
  input  logic                      beat,
  output logic [8*OUTPUT_WIDTH-1:0] slot_a,
  output logic [8*OUTPUT_WIDTH-1:0] slot_b
);

  function automatic logic [OUTPUT_WIDTH-1:0] ext8(input logic [7:0] v, input logic s);
    return {{(OUTPUT_WIDTH-8){s & v[7]}}, v};
  endfunction

  function automatic logic [OUTPUT_WIDTH-1:0] ext16(input logic [15:0] v, input logic s);
    return {{(OUTPUT_WIDTH-16){s & v[15]}}, v};
  endfunction

  logic [1:0] ai_s;
  logic [1:0] bi_s;
  logic       ax_s;
  logic       bx_s;
  logic       use16_s;
  logic       zero_s;

  // Per-slot halfword/byte selection and extension
  always_comb begin
    slot_a  = '0;
    slot_b  = '0;
    ai_s    = 2'd0;
    bi_s    = 2'd0;
    ax_s    = 1'b0;
    bx_s    = 1'b0;
    use16_s = 1'b1;
    zero_s  = 1'b0;
    for (int k = 0; k < 8; k++) begin
      ai_s    = 2'd0;
      bi_s    = 2'd0;
      ax_s    = 1'b0;
      bx_s    = 1'b0;
      use16_s = 1'b1;
      zero_s  = 1'b0;
      case (sew)
        SEW8: begin
          use16_s = 1'b0;
        end
        SEW16: begin
          ai_s   = k[1:0];
          bi_s   = k[1:0];
          ax_s   = a_signed;
          bx_s   = b_signed;
          zero_s = (k >= 4);
        end
        SEW32: begin
          // Local index bit 1 picks A's hi half, bit 0 picks B's; only hi halves carry sign
          ai_s = {k[2], k[1]};
          bi_s = {k[2], k[0]};
          ax_s = a_signed & k[1];
          bx_s = b_signed & k[0];
        end
        SEW64: begin
          ai_s = {beat, k[2]};
          bi_s = k[1:0];
          ax_s = a_signed & (ai_s == 2'd3);
          bx_s = b_signed & (bi_s == 2'd3);
        end
        default: begin
          zero_s = 1'b1;
        end
      endcase
      if (zero_s) begin
        slot_a[k*OUTPUT_WIDTH +: OUTPUT_WIDTH] = '0;
        slot_b[k*OUTPUT_WIDTH +: OUTPUT_WIDTH] = '0;
      end else if (use16_s) begin
        slot_a[k*OUTPUT_WIDTH +: OUTPUT_WIDTH] = ext16(a[16*ai_s +: 16], ax_s);
        slot_b[k*OUTPUT_WIDTH +: OUTPUT_WIDTH] = ext16(b[16*bi_s +: 16], bx_s);
      end else begin
        slot_a[k*OUTPUT_WIDTH +: OUTPUT_WIDTH] = ext8(a[8*k +: 8], a_signed);
        slot_b[k*OUTPUT_WIDTH +: OUTPUT_WIDTH] = ext8(b[8*k +: 8], b_signed);
      end
    end
  end

endmodule

// File: rtl/operand_select_seq.sv
// Handshaked vALU multiplier operand selector; SEW=64 requests are held and
// emitted as two beats, everything else as one.
module operand_select_seq
  import vALU_pkg::*;
#(
  parameter  int LANES        = 1,
  parameter  int OUTPUT_WIDTH = OUTPUT_WIDTH_DEF,
  parameter  int OPSEL_WIDTH  = 2,
  parameter  int SEW_WIDTH    = 2,
  localparam int INPUT_WIDTH  = 64*LANES,
  localparam int NSLOT        = 8*LANES
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [INPUT_WIDTH-1:0]        vec0,
  input  logic [INPUT_WIDTH-1:0]        vec1,
  input  logic [OPSEL_WIDTH-1:0]        opSel,
  input  logic [SEW_WIDTH-1:0]          sew,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NSLOT*OUTPUT_WIDTH-1:0] out_a,
  output logic [NSLOT*OUTPUT_WIDTH-1:0] out_b,
  output logic [SEW_WIDTH-1:0]          out_sew,
  output logic                          out_beat,
  output logic                          out_last
);

  state_e                        state_r;
  state_e                        state_s;
  logic [INPUT_WIDTH-1:0]        hold_a_r;
  logic [INPUT_WIDTH-1:0]        hold_b_r;
  logic [OPSEL_WIDTH-1:0]        hold_sel_r;
  logic [INPUT_WIDTH-1:0]        src_a_s;
  logic [INPUT_WIDTH-1:0]        src_b_s;
  logic [OPSEL_WIDTH-1:0]        src_sel_s;
  logic [SEW_WIDTH-1:0]          src_sew_s;
  logic                          src_beat_s;
  logic                          a_signed_s;
  logic                          b_signed_s;
  logic                          in_ready_s;
  logic                          accept_s;
  logic                          handshake_s;
  logic                          capture_s;
  logic                          load_s;
  logic [NSLOT*OUTPUT_WIDTH-1:0] slot_a_s;
  logic [NSLOT*OUTPUT_WIDTH-1:0] slot_b_s;
  logic                          out_valid_r;
  logic [NSLOT*OUTPUT_WIDTH-1:0] out_a_r;
  logic [NSLOT*OUTPUT_WIDTH-1:0] out_b_r;
  logic [SEW_WIDTH-1:0]          out_sew_r;
  logic                          out_beat_r;
  logic                          out_last_r;

  assign in_ready_s  = (state_r == S_IDLE) & (~out_valid_r | out_ready);
  assign accept_s    = in_valid & in_ready_s;
  assign handshake_s = out_valid_r & out_ready;
  assign capture_s   = accept_s & (sew == SEW64);
  assign load_s      = accept_s | ((state_r == S_HI) & handshake_s);

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_a     = out_a_r;
  assign out_b     = out_b_r;
  assign out_sew   = out_sew_r;
  assign out_beat  = out_beat_r;
  assign out_last  = out_last_r;

  // Slot mapper source: live request in S_IDLE, captured SEW=64 operands for beat 1
  always_comb begin
    src_a_s    = vec0;
    src_b_s    = vec1;
    src_sel_s  = opSel;
    src_sew_s  = sew;
    src_beat_s = 1'b0;
    if (state_r == S_HI) begin
      src_a_s    = hold_a_r;
      src_b_s    = hold_b_r;
      src_sel_s  = hold_sel_r;
      src_sew_s  = SEW64;
      src_beat_s = 1'b1;
    end else begin
      src_a_s    = vec0;
      src_b_s    = vec1;
      src_sel_s  = opSel;
      src_sew_s  = sew;
      src_beat_s = 1'b0;
    end
    a_signed_s = (src_sel_s == OPSEL_SS) | (src_sel_s == OPSEL_SU) | (src_sel_s == OPSEL_SS_ALT);
    b_signed_s = (src_sel_s == OPSEL_SS) | (src_sel_s == OPSEL_SS_ALT);
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    operand_slice #(
      .OUTPUT_WIDTH (OUTPUT_WIDTH),
      .SEW_WIDTH    (SEW_WIDTH)
    ) u_slice (
      .a        (src_a_s[64*l +: 64]),
      .b        (src_b_s[64*l +: 64]),
      .sew      (src_sew_s),
      .a_signed (a_signed_s),
      .b_signed (b_signed_s),
      .beat     (src_beat_s),
      .slot_a   (slot_a_s[8*OUTPUT_WIDTH*l +: 8*OUTPUT_WIDTH]),
      .slot_b   (slot_b_s[8*OUTPUT_WIDTH*l +: 8*OUTPUT_WIDTH])
    );
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (capture_s) begin
          state_s = S_HI;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_HI: begin
        if (handshake_s) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_HI;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // State register and SEW=64 operand hold registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= S_IDLE;
      hold_a_r   <= '0;
      hold_b_r   <= '0;
      hold_sel_r <= '0;
    end else begin
      state_r <= state_s;
      if (capture_s) begin
        hold_a_r   <= vec0;
        hold_b_r   <= vec1;
        hold_sel_r <= opSel;
      end
    end
  end

  // Output beat registers: load on accept or beat-1 transition, else hold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_r <= 1'b0;
      out_a_r     <= '0;
      out_b_r     <= '0;
      out_sew_r   <= '0;
      out_beat_r  <= 1'b0;
      out_last_r  <= 1'b0;
    end else if (load_s) begin
      out_valid_r <= 1'b1;
      out_a_r     <= slot_a_s;
      out_b_r     <= slot_b_s;
      out_sew_r   <= src_sew_s;
      out_beat_r  <= src_beat_s;
      out_last_r  <= (src_sew_s != SEW64) | src_beat_s;
    end else if (handshake_s) begin
      out_valid_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_select_seq.sv
// Randomised scoreboard bench for operand_select_seq with a slot-level
// reference model, plus directed backpressure, throughput and reset cases.
module tb_operand_select_seq;

  localparam int LANES = 2;
  localparam int OW    = 18;
  localparam int IW    = 64*LANES;
  localparam int CW    = 8*LANES*OW;

  typedef struct packed {
    logic [CW-1:0] a;
    logic [CW-1:0] b;
    logic [1:0]    sew;
    logic          beat;
    logic          last;
  } beat_t;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] vec0;
  logic [IW-1:0] vec1;
  logic [1:0]    opSel;
  logic [1:0]    sew;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_a;
  logic [CW-1:0] out_b;
  logic [1:0]    out_sew;
  logic          out_beat;
  logic          out_last;

  int    n_cmp = 0;
  int    n_err = 0;
  int    cyc = 0;
  int    rmode = 0;
  int    waited;
  int    waited_b;
  beat_t exp_q[$];
  bit    acc_at[int];

  operand_select_seq #(.LANES(LANES), .OUTPUT_WIDTH(OW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .vec0      (vec0),
    .vec1      (vec1),
    .opSel     (opSel),
    .sew       (sew),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_sew   (out_sew),
    .out_beat  (out_beat),
    .out_last  (out_last)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: sign/zero extension of a w-bit field as plain integer arithmetic
  function automatic logic [OW-1:0] ext_val(input logic [15:0] f, input int w, input bit sg);
    longint v;
    v = longint'(f);
    if (sg && f[w-1]) v = v - (longint'(1) << w);
    return v[OW-1:0];
  endfunction

  function automatic logic [OW-1:0] model_opnd(input logic [63:0] w, input int k, input logic [1:0] s,
                                               input bit sg, input bit is_a, input bit bt);
    logic [15:0] h [4];
    int idx;
    bit hi;
    for (int i = 0; i < 4; i++) h[i] = w[16*i +: 16];
    case (s)
      2'd0: return ext_val({8'h00, w[8*k +: 8]}, 8, sg);
      2'd1: begin
        if (k < 4) return ext_val(h[k], 16, sg);
        return '0;
      end
      2'd2: begin
        hi  = is_a ? ((k % 4) >= 2) : ((k % 2) == 1);
        idx = 2*(k/4) + (hi ? 1 : 0);
        return ext_val(h[idx], 16, sg && hi);
      end
      default: begin
        idx = is_a ? (k/4 + (bt ? 2 : 0)) : (k % 4);
        return ext_val(h[idx], 16, sg && (idx == 3));
      end
    endcase
  endfunction

  function automatic beat_t model_beat(input logic [IW-1:0] v0, input logic [IW-1:0] v1,
                                       input logic [1:0] sel, input logic [1:0] s, input bit bt);
    beat_t r;
    bit    as_;
    bit    bs_;
    as_ = (sel == 2'b01) || (sel == 2'b10) || (sel == 2'b11);
    bs_ = (sel == 2'b01) || (sel == 2'b11);
    r = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int k = 0; k < 8; k++) begin
        r.a[(8*l+k)*OW +: OW] = model_opnd(v0[64*l +: 64], k, s, as_, 1'b1, bt);
        r.b[(8*l+k)*OW +: OW] = model_opnd(v1[64*l +: 64], k, s, bs_, 1'b0, bt);
      end
    end
    r.sew  = s;
    r.beat = bt;
    r.last = (s != 2'b11) || bt;
    return r;
  endfunction

  function automatic logic [IW-1:0] rnd_vec();
    logic [IW-1:0] v;
    for (int i = 0; i < 2*LANES; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic send(input logic [IW-1:0] v0, input logic [IW-1:0] v1, input logic [1:0] sel,
                      input logic [1:0] s, output int wcnt);
    bit ok;
    ok   = 1'b0;
    wcnt = 0;
    in_valid = 1'b1;
    vec0 = v0;
    vec1 = v1;
    opSel = sel;
    sew = s;
    while (!ok && wcnt <= 100) begin
      @(negedge clk);
      if (rst && in_ready) begin
        ok = 1'b1;
        acc_at[cyc] = 1'b1;
        exp_q.push_back(model_beat(v0, v1, sel, s, 1'b0));
        if (s == 2'b11) exp_q.push_back(model_beat(v0, v1, sel, s, 1'b1));
      end else begin
        wcnt++;
      end
    end
    chk("accept_in_time", CW'(ok), CW'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic drop();
    in_valid = 1'b0;
    vec0 = rnd_vec();
    vec1 = rnd_vec();
    opSel = 2'($urandom);
    sew = 2'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", CW'(exp_q.size()), CW'(0));
    @(posedge clk);
    #1;
  endtask

  // Downstream ready generator: 0 = always ready, 1 = random, other = stalled
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (rmode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every output handshake and checks protocol rules
  initial begin
    bit            stall_q;
    logic [CW-1:0] snap_a;
    logic [CW-1:0] snap_b;
    logic [4:0]    snap_c;
    beat_t         e;
    stall_q = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        stall_q = 1'b0;
      end else begin
        if (stall_q) begin
          chk("stall_hold_a", out_a, snap_a);
          chk("stall_hold_b", out_b, snap_b);
          chk("stall_hold_ctrl", CW'({out_valid, out_sew, out_beat, out_last}), CW'(snap_c));
        end
        if (acc_at.exists(cyc - 1)) chk("latency_valid", CW'(out_valid), CW'(1));
        if (out_valid && !out_last) chk("hi_in_ready", CW'(in_ready), CW'(0));
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", CW'(out_valid), CW'(0));
          end else begin
            e = exp_q.pop_front();
            chk("beat_a", out_a, e.a);
            chk("beat_b", out_b, e.b);
            chk("beat_ctrl", CW'({out_sew, out_beat, out_last}), CW'({e.sew, e.beat, e.last}));
          end
        end
        stall_q = out_valid && !out_ready;
        if (stall_q) begin
          chk("bp_in_ready", CW'(in_ready), CW'(0));
          snap_a = out_a;
          snap_b = out_b;
          snap_c = {out_valid, out_sew, out_beat, out_last};
        end
      end
    end
  end

  initial begin
    int n;
    rst = 1'b0;
    in_valid = 1'b0;
    vec0 = '0;
    vec1 = '0;
    opSel = 2'b00;
    sew = 2'b00;
    rmode = 0;

    @(negedge clk);
    chk("rst_out_valid", CW'(out_valid), CW'(0));
    chk("rst_out_a", out_a, '0);
    chk("rst_out_b", out_b, '0);
    chk("rst_ctrl", CW'({out_sew, out_beat, out_last}), CW'(0));
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_in_ready", CW'(in_ready), CW'(1));
    @(posedge clk);
    #1;

    // SEW=8 signed x signed
    rmode = 2;
    send(IW'(128'h80), IW'(128'h7F), 2'b01, 2'b00, waited);
    drop();
    @(negedge clk);
    chk("d8_a0", CW'(out_a[OW-1:0]), CW'(18'h3FF80));
    chk("d8_b0", CW'(out_b[OW-1:0]), CW'(18'h0007F));
    chk("d8_last", CW'(out_last), CW'(1));
    rmode = 0;
    drain();

    // SEW=16 unsigned; upper four slots of each lane stay zero
    rmode = 2;
    send(IW'(128'hFFFF), IW'(128'h0), 2'b00, 2'b01, waited);
    drop();
    @(negedge clk);
    chk("d16_a0", CW'(out_a[OW-1:0]), CW'(18'h0FFFF));
    chk("d16_hi_zero", CW'(out_a[8*OW-1:4*OW]), CW'(0));
    rmode = 0;
    drain();

    // SEW=32 signed x unsigned
    rmode = 2;
    send(IW'(128'h8000_1234), IW'(128'h8000_0001), 2'b10, 2'b10, waited);
    drop();
    @(negedge clk);
    chk("d32_s0", CW'({out_a[OW-1:0], out_b[OW-1:0]}), CW'({18'h01234, 18'h00001}));
    chk("d32_s3", CW'({out_a[3*OW +: OW], out_b[3*OW +: OW]}), CW'({18'h38000, 18'h08000}));
    rmode = 0;
    drain();

    // SEW=64 two-beat sequence
    rmode = 2;
    send(IW'(128'h8000_0000_0000_0001), IW'(128'h0), 2'b01, 2'b11, waited);
    drop();
    @(negedge clk);
    chk("d64_b0_a0", CW'(out_a[OW-1:0]), CW'(18'h00001));
    chk("d64_b0_last", CW'(out_last), CW'(0));
    chk("d64_b0_in_ready", CW'(in_ready), CW'(0));
    rmode = 0;
    n = 0;
    while (!(out_valid && out_beat) && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("d64_b1_seen", CW'(out_beat), CW'(1));
    chk("d64_b1_a4", CW'(out_a[4*OW +: OW]), CW'(18'h38000));
    chk("d64_b1_last", CW'(out_last), CW'(1));
    drain();

    // Backpressure: second request waits while the first beat is stalled
    rmode = 2;
    @(posedge clk);
    #1;
    send(rnd_vec(), rnd_vec(), 2'($urandom), 2'b00, waited);
    fork
      send(rnd_vec(), rnd_vec(), 2'($urandom), 2'b10, waited_b);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("bp_stall_in_ready", CW'(in_ready), CW'(0));
          chk("bp_stall_valid", CW'(out_valid), CW'(1));
        end
        rmode = 0;
      end
    join
    chk("bp_waited", CW'(waited_b >= 3), CW'(1));
    drop();
    drain();

    // Back-to-back SEW=8 with downstream always ready
    for (int i = 0; i < 8; i++) begin
      send(rnd_vec(), rnd_vec(), 2'($urandom), 2'b00, waited);
      chk("b2b_no_stall", CW'(waited), CW'(0));
    end
    drop();
    drain();

    // Randomised traffic with random downstream stalls and idle gaps
    rmode = 1;
    for (int i = 0; i < 250; i++) begin
      send(rnd_vec(), rnd_vec(), 2'($urandom), 2'($urandom), waited);
      if ($urandom_range(0, 3) == 0) begin
        drop();
        @(posedge clk);
        #1;
      end
    end
    drop();
    drain();

    // Reset during S_HI discards beat 1
    rmode = 2;
    @(posedge clk);
    #1;
    send(rnd_vec(), rnd_vec(), 2'b11, 2'b11, waited);
    drop();
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", CW'(out_valid), CW'(0));
    chk("mid_rst_out_a", out_a, '0);
    exp_q.delete();
    #20;
    rst = 1'b1;
    #1;
    chk("post_rst_in_ready", CW'(in_ready), CW'(1));
    rmode = 0;
    @(negedge clk);
    chk("post_rst_no_beat1", CW'(out_valid), CW'(0));
    @(posedge clk);
    #1;
    send(rnd_vec(), rnd_vec(), 2'($urandom), 2'b00, waited);
    drop();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
